data_bus_arbiter: RTL and testbench

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

---
 rtl/data_bus_arbiter_if.sv | 35 +++
 rtl/data_bus_arbiter.sv | 118 +++++++++++
 tb/tb_data_bus_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// Data-bus arbitration signal bundle.
// master: arbiter side (drives slot strobe, grant, tenure id, data phase, grant count).
// slave : requester side (drives the per-board request vector).
//   data_bus_request      requester -> arbiter, bit i = board i wants the data bus
//   addr_data_arbitration arbiter -> requesters, 0 = data-arbitration slot
//   data_bus_gain         one-hot grant, valid only in the arbitration slot
//   grant_id              board number of the current/last tenure owner
//   data_phase            1 in the cycle the winner drives data_bus
//   transfer_count        saturating number of grants since reset
interface data_bus_arbiter_if;
  logic [7:0]  data_bus_request;
  logic        addr_data_arbitration;
  logic [7:0]  data_bus_gain;
  logic [2:0]  grant_id;
  logic        data_phase;
  logic [15:0] transfer_count;

  modport master (
    input  data_bus_request,
    output addr_data_arbitration,
    output data_bus_gain,
    output grant_id,
    output data_phase,
    output transfer_count
  );

  modport slave (
    output data_bus_request,
    input  addr_data_arbitration,
    input  data_bus_gain,
    input  grant_id,
    input  data_phase,
    input  transfer_count
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin data-bus arbiter.
// Each bus cycle runs ADDR (ADDR_CYCLES cycles) -> DARB (1 cycle). A request seen in DARB
// produces a combinational one-hot grant, then ID (winner drives data_bus_id) and DATA
// (winner drives data_bus) follow before returning to ADDR. An empty DARB goes back to ADDR.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  data_bus_arbiter_if.master (request in; slot strobe, grant, id, data phase, count out)
module data_bus_arbiter #(
  parameter int unsigned ADDR_CYCLES = 1,  // 1..4
  parameter int unsigned NUM_REQ     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  data_bus_arbiter_if.master     bus
);

  localparam logic [1:0] StAddr = 2'd0;
  localparam logic [1:0] StDarb = 2'd1;
  localparam logic [1:0] StId   = 2'd2;
  localparam logic [1:0] StData = 2'd3;

  localparam logic [1:0]  LastPhase = 2'(ADDR_CYCLES - 1);
  localparam logic [15:0] CountMax  = 16'hFFFF;

  logic [1:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  gid_q, gid_d;
  logic [15:0] count_q, count_d;

  logic [7:0]  req_valid;
  logic        win_valid;
  logic [2:0]  win_idx;
  logic [2:0]  cand;
  logic        grant;

  // Boards at or above NUM_REQ are not populated.
  always_comb begin
    req_valid = 8'h00;
    for (int unsigned i = 0; i < 8; i++) begin
      req_valid[i] = bus.data_bus_request[i] && (i < NUM_REQ);
    end
  end

  // Search from the highest offset down so the last hit is the one closest to ptr_q.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (req_valid[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    count_d = count_q;
    grant   = 1'b0;
    case (state_q)
      StAddr: begin
        if (phase_q == LastPhase) begin
          phase_d = 2'd0;
          state_d = StDarb;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      StDarb: begin
        if (win_valid) begin
          grant   = 1'b1;
          state_d = StId;
          ptr_d   = win_idx + 3'd1;  // wraps 7 -> 0
          gid_d   = win_idx;
          if (count_q != CountMax) begin
            count_d = count_q + 16'd1;
          end
        end else begin
          state_d = StAddr;
        end
      end
      StId:    state_d = StData;
      StData:  state_d = StAddr;
      default: state_d = StAddr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StAddr;
      phase_q <= 2'd0;
      ptr_q   <= 3'd0;
      gid_q   <= 3'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      count_q <= count_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops them at once.
  assign bus.addr_data_arbitration = (state_q != StDarb);
  assign bus.data_bus_gain         = grant ? (8'd1 << win_idx) : 8'd0;
  assign bus.grant_id              = gid_q;
  assign bus.data_phase            = (state_q == StData);
  assign bus.transfer_count        = count_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;

  localparam int unsigned MainAc = 1;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  data_bus_arbiter_if bus0 ();
  data_bus_arbiter_if bus3 ();

  data_bus_arbiter #(.ADDR_CYCLES(MainAc), .NUM_REQ(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  data_bus_arbiter #(.ADDR_CYCLES(3), .NUM_REQ(8)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // Reference model of the main instance: 0 ADDR, 1 DARB, 2 ID, 3 DATA.
  int          m_st;
  int          m_ph;
  int          m_ptr;
  int          m_gid;
  logic [15:0] m_cnt;

  logic [31:0] exp_q[$];   // expected output vector per cycle
  int          ten_q[$];   // expected owner of each pending data tenure
  int          obs_q[$];   // winners seen on the main instance
  int          g3_t[$];    // cycle numbers of grants on the ADDR_CYCLES=3 instance
  logic [7:0]  g3_v[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_ph  = 0;
    m_ptr = 0;
    m_gid = 0;
    m_cnt = 16'd0;
  endtask

  function automatic int obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return -1;
  endfunction

  // One clock: drive at the negedge, predict, compare 1 time unit later, advance model.
  task automatic cycle(input logic [7:0] req);
    int          w;
    logic [7:0]  egain;
    logic [31:0] got;
    bus0.data_bus_request = req;
    w = -1;
    if (rst && m_st == 1) begin
      for (int k = 0; k < 8; k++) begin
        if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      end
    end
    egain = (w >= 0) ? (8'd1 << w) : 8'd0;
    exp_q.push_back({3'b000, (m_st != 1), egain, 3'(m_gid), (m_st == 3), m_cnt});
    if (w >= 0) ten_q.push_back(w);
    #1;
    got = {3'b000, bus0.addr_data_arbitration, bus0.data_bus_gain, bus0.grant_id,
           bus0.data_phase, bus0.transfer_count};
    check("cycle_outputs", got, exp_q.pop_front());
    if (bus0.data_phase) begin
      if (ten_q.size() == 0) check("tenure_orphan", 32'(bus0.data_phase), 32'd0);
      else check("tenure_id", 32'(bus0.grant_id), 32'(ten_q.pop_front()));
    end
    for (int i = 0; i < 8; i++) begin
      if (bus0.data_bus_gain[i]) obs_q.push_back(i);
    end
    if (bus3.data_bus_gain != 8'd0) begin
      g3_t.push_back(cyc);
      g3_v.push_back(bus3.data_bus_gain);
    end
    if (rst) begin
      case (m_st)
        0: begin
          if (m_ph + 1 >= int'(MainAc)) begin
            m_st = 1;
            m_ph = 0;
          end else begin
            m_ph++;
          end
        end
        1: begin
          if (w >= 0) begin
            m_gid = w;
            m_ptr = (w + 1) % 8;
            if (m_cnt != 16'hFFFF) m_cnt++;
            m_st = 2;
          end else begin
            m_st = 0;
          end
        end
        2: m_st = 3;
        default: m_st = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input logic [7:0] req, input int target, input int budget,
                           input string tag);
    int left;
    left = budget;
    while (obs_q.size() < target && left > 0) begin
      cycle(req);
      left--;
    end
    check(tag, 32'(obs_q.size()), 32'(target));
  endtask

  task automatic run3_until(input int target, input int budget, input string tag);
    int left;
    left = budget;
    while (g3_t.size() < target && left > 0) begin
      cycle(8'h00);
      left--;
    end
    check(tag, 32'(g3_t.size()), 32'(target));
  endtask

  initial begin
    rst  = 1'b0;
    rst3 = 1'b0;
    bus0.data_bus_request = 8'h00;
    bus3.data_bus_request = 8'h00;
    model_reset();
    @(negedge clk);

    // Held in reset.
    cycle(8'hFF);
    cycle(8'hFF);
    rst  = 1'b1;
    rst3 = 1'b1;

    // Idle bus: 1,0,1,0 slot pattern, no grants.
    for (int i = 0; i < 8; i++) cycle(8'h00);
    check("idle_no_grants", 32'(obs_q.size()), 32'd0);

    // Single requester 4.
    for (int i = 0; i < 13; i++) cycle(8'h10);
    check("req10_grant_count", 32'(obs_q.size()), 32'd3);
    check("req10_first", 32'(obs_at(0)), 32'd4);
    check("req10_ptr", 32'(dut.ptr_q), 32'd5);

    // All requesting from reset: 0..7 then wrap to 0.
    rst = 1'b0;
    model_reset();
    ten_q.delete();
    cycle(8'h00);
    rst = 1'b1;
    obs_q.delete();
    run_until(8'hFF, 9, 60, "all_req_timeout");
    for (int i = 0; i < 9; i++) check("all_req_order", 32'(obs_at(i)), 32'(i % 8));
    cycle(8'hFF);
    check("all_req_count", 32'(bus0.transfer_count), 32'd9);

    // Reset during DATA abandons the tenure immediately.
    for (int i = 0; i < 8 && m_st != 3; i++) cycle(8'hFF);
    check("pre_rst_dphase", 32'(bus0.data_phase), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_dphase", 32'(bus0.data_phase), 32'd0);
    check("rst_gain", 32'(bus0.data_bus_gain), 32'd0);
    check("rst_adarb", 32'(bus0.addr_data_arbitration), 32'd1);
    model_reset();
    ten_q.delete();
    exp_q.delete();
    cycle(8'hFF);
    rst = 1'b1;
    obs_q.delete();
    run_until(8'hFF, 1, 10, "post_rst_timeout");
    check("post_rst_first", 32'(obs_at(0)), 32'd0);

    // Pointer to 6, then 8'h41 grants 6 and then 0.
    obs_q.delete();
    run_until(8'h20, 1, 10, "ptr6_timeout");
    check("ptr6_setup", 32'(obs_at(0)), 32'd5);
    run_until(8'h41, 3, 20, "wrap_timeout");
    check("wrap_first", 32'(obs_at(1)), 32'd6);
    check("wrap_second", 32'(obs_at(2)), 32'd0);
    for (int i = 0; i < 4; i++) cycle(8'h00);

    // ADDR_CYCLES=3 instance: grant spacing and count saturation.
    g3_t.delete();
    g3_v.delete();
    bus3.data_bus_request = 8'h04;
    for (int i = 0; i < 20; i++) cycle(8'h00);
    check("ac3_enough", 32'(g3_t.size() >= 3), 32'd1);
    for (int i = 1; i < g3_t.size(); i++) check("ac3_spacing", 32'(g3_t[i] - g3_t[i-1]), 32'd6);
    for (int i = 0; i < g3_v.size(); i++) check("ac3_gain", 32'(g3_v[i]), 32'h04);
    cycle(8'h00);
    check("ac3_count", 32'(bus3.transfer_count), 32'(g3_t.size()));

    bus3.data_bus_request = 8'h00;
    for (int i = 0; i < 8; i++) cycle(8'h00);
    force dut3.count_q = 16'hFFFE;
    cycle(8'h00);
    release dut3.count_q;
    #1;
    check("sat_forced", 32'(bus3.transfer_count), 32'hFFFE);
    g3_t.delete();
    bus3.data_bus_request = 8'h04;
    run3_until(1, 12, "sat_g1_timeout");
    check("sat_after_1", 32'(bus3.transfer_count), 32'hFFFF);
    run3_until(2, 12, "sat_g2_timeout");
    check("sat_after_2", 32'(bus3.transfer_count), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
